// File: rtl/pipeline_sequencer_pkg.sv
// Shared constants for the pipeline sequencer: state encoding, NOP word and
// redirect-priority codes used to arbitrate branch / stall / jump.
package pipeline_sequencer_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_STEP_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN     = 2'd2;
  localparam logic [1:0] ST_HALT      = 2'd3;

  localparam logic [31:0] NOP_WORD = 32'h0000_0020;

  localparam logic [1:0] PRIO_BRANCH = 2'd0;
  localparam logic [1:0] PRIO_STALL  = 2'd1;
  localparam logic [1:0] PRIO_JUMP   = 2'd2;
  localparam logic [1:0] PRIO_NONE   = 2'd3;

  // Branch beats load-use stall beats jump.
  function automatic logic [1:0] redirect_prio(input logic branch, input logic stall,
                                               input logic jump);
    if (branch)     return PRIO_BRANCH;
    else if (stall) return PRIO_STALL;
    else if (jump)  return PRIO_JUMP;
    else            return PRIO_NONE;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_hazard_c
);

  // $zero is never a real dependency.
  assign o_hazard_c = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control: stage enables, flushes, redirect arbitration, drain/halt
// sequencing and single-step mode, plus saturating stall/flush counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH   = 128,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      pc,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_target,
  output logic             pipe_en,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             redirect,
  output logic [31:0]      redirect_addr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]         r_state;
  logic               r_started;
  logic [DRAIN_W-1:0] r_drain;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic [1:0]         w_state;
  logic [1:0]         w_state_nxt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic               w_hazard;
  logic               w_halt_cond;
  logic               w_stall_inc;
  logic               w_flush_inc;
  logic [1:0]         w_prio;

  hazard_detect u_hazard (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (id_uses_rt),
    .o_hazard_c    (w_hazard)
  );

  // Until the first edge after reset release the mode pin selects RUN vs STEP_WAIT.
  assign w_state = r_started ? r_state : (run_mode ? ST_STEP_WAIT : ST_RUN);

  // Word index at or past the last legal word, or any bit above the IMEM window.
  assign w_halt_cond = halt_req || ((pc >> 2) >= 32'(IMEM_DEPTH - 1));
  assign w_prio      = redirect_prio(ex_branch_taken, w_hazard, id_jump);

  assign halted    = (w_state == ST_HALT);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_comb begin
    pipe_en       = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_state_nxt   = w_state;
    w_drain_nxt   = r_drain;

    case (w_state)
      ST_RUN, ST_DRAIN: pipe_en = 1'b1;
      ST_STEP_WAIT:     pipe_en = step;
      default:          pipe_en = 1'b0;
    endcase

    if (pipe_en) begin
      if (w_state == ST_DRAIN) begin
        // Fetch frozen, bubbles into IF/ID; ID/EX still honours branch/stall.
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = ex_branch_taken || w_hazard;
        w_flush_inc = ex_branch_taken;
        w_stall_inc = w_hazard && !ex_branch_taken;
      end else begin
        case (w_prio)
          PRIO_BRANCH: begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            redirect      = 1'b1;
            redirect_addr = ex_branch_target;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            w_flush_inc   = 1'b1;
          end
          PRIO_STALL: begin
            id_ex_flush = 1'b1;
            w_stall_inc = 1'b1;
          end
          PRIO_JUMP: begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            redirect      = 1'b1;
            redirect_addr = id_jump_target;
            if_id_flush   = 1'b1;
            w_flush_inc   = 1'b1;
          end
          default: begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
        endcase
      end
    end

    case (w_state)
      ST_RUN, ST_STEP_WAIT: begin
        if (pipe_en && w_halt_cond) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_state_nxt = run_mode ? ST_STEP_WAIT : ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRAIN_W'(DRAIN_CYCLES - 1)) w_state_nxt = ST_HALT;
        else                                       w_drain_nxt = r_drain + DRAIN_W'(1);
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_started   <= 1'b0;
      r_drain     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_started <= 1'b1;
      r_state   <= w_state_nxt;
      r_drain   <= w_drain_nxt;
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized + directed bench for pipeline_sequencer against a cycle-level
// behavioural model of the control rules.
module tb_pipeline_sequencer;

  localparam int unsigned CW    = 4;
  localparam int unsigned SAT   = (1 << CW) - 1;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned DRAIN = 4;

  localparam int MODE_FREE = 0, MODE_STEP = 1, MODE_DRAIN = 2, MODE_STOP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_mode, step, halt_req;
  logic [31:0]   pc;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, ex_branch_taken, id_jump;
  logic [31:0]   ex_branch_target, id_jump_target;
  logic          pipe_en, pc_en, if_id_en, if_id_flush, id_ex_flush, redirect, halted;
  logic [31:0]   redirect_addr;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_sequencer #(.IMEM_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step(step), .halt_req(halt_req), .pc(pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target), .pipe_en(pipe_en), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_mode, m_left, m_stall, m_flush;
  int n_mode, n_left, n_stall, n_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    step = 0; halt_req = 0; pc = 32'h0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0; ex_branch_target = 0;
    id_jump = 0; id_jump_target = 0;
  endtask

  // Evaluate the rules for this cycle, compare every output, prepare next model state.
  task automatic model_check();
    bit en, load_use, wants_halt, e_pc, e_ifen, e_iff, e_ief, e_red, inc_s, inc_f;
    logic [31:0] e_addr;
    en = (m_mode == MODE_FREE) || (m_mode == MODE_DRAIN) || (m_mode == MODE_STEP && step);
    load_use = ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    {e_pc, e_ifen, e_iff, e_ief, e_red, inc_s, inc_f} = '0;
    e_addr = 0;
    if (en && m_mode == MODE_DRAIN) begin
      e_ifen = 1; e_iff = 1;
      e_ief = ex_branch_taken || load_use;
      inc_f = ex_branch_taken;
      inc_s = load_use && !ex_branch_taken;
    end else if (en && ex_branch_taken) begin
      e_pc = 1; e_ifen = 1; e_red = 1; e_addr = ex_branch_target; e_iff = 1; e_ief = 1; inc_f = 1;
    end else if (en && load_use) begin
      e_ief = 1; inc_s = 1;
    end else if (en && id_jump) begin
      e_pc = 1; e_ifen = 1; e_red = 1; e_addr = id_jump_target; e_iff = 1; inc_f = 1;
    end else if (en) begin
      e_pc = 1; e_ifen = 1;
    end
    check("pipe_en", pipe_en, en);
    check("pc_en", pc_en, e_pc);
    check("if_id_en", if_id_en, e_ifen);
    check("if_id_flush", if_id_flush, e_iff);
    check("id_ex_flush", id_ex_flush, e_ief);
    check("redirect", redirect, e_red);
    check("redirect_addr", redirect_addr, e_addr);
    check("halted", halted, m_mode == MODE_STOP);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);

    n_stall = (inc_s && m_stall < SAT) ? m_stall + 1 : m_stall;
    n_flush = (inc_f && m_flush < SAT) ? m_flush + 1 : m_flush;
    n_left  = m_left;
    n_mode  = m_mode;
    wants_halt = halt_req || (int'(pc[10:2]) >= DEPTH - 1) || (pc[31:11] != 0);
    if (m_mode == MODE_FREE || m_mode == MODE_STEP) begin
      if (en && wants_halt) begin
        n_mode = MODE_DRAIN; n_left = DRAIN;
      end else begin
        n_mode = run_mode ? MODE_STEP : MODE_FREE;
      end
    end else if (m_mode == MODE_DRAIN) begin
      n_left = m_left - 1;
      if (n_left == 0) n_mode = MODE_STOP;
    end
  endtask

  task automatic step_cycle();
    model_check();
    @(posedge clk);
    m_mode = n_mode; m_left = n_left; m_stall = n_stall; m_flush = n_flush;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit rm);
    rst = 0; run_mode = rm; set_idle();
    #1;
    check("rst_halted", halted, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_pipe_en", pipe_en, !rm);
    @(negedge clk);
    rst = 1;
    m_mode = rm ? MODE_STEP : MODE_FREE;
    m_left = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic rand_inputs(input bit allow_mode_change);
    if (allow_mode_change && $urandom_range(0, 29) == 0) run_mode = ~run_mode;
    step            = 1'($urandom_range(0, 1));
    halt_req        = ($urandom_range(0, 79) == 0);
    ex_mem_read     = 1'($urandom_range(0, 1));
    ex_rt           = 5'($urandom_range(0, 3));
    id_rs           = 5'($urandom_range(0, 3));
    id_rt           = 5'($urandom_range(0, 3));
    id_uses_rt      = 1'($urandom_range(0, 1));
    ex_branch_taken = ($urandom_range(0, 5) == 0);
    ex_branch_target = $urandom & 32'hFFFF_FFFC;
    id_jump         = ($urandom_range(0, 3) == 0);
    id_jump_target  = $urandom & 32'hFFFF_FFFC;
    case ($urandom_range(0, 59))
      0:       pc = 32'h0000_01FC;
      1:       pc = 32'h0000_01F8;
      2:       pc = 32'h0000_0800 | (32'($urandom_range(0, 15)) << 2);
      default: pc = 32'($urandom_range(0, 123)) << 2;
    endcase
  endtask

  initial begin
    int bubbles, pe_cycles;
    rst = 0; run_mode = 0; set_idle();
    @(negedge clk);

    // load-use stall, then ex_rt = 0 gives no stall
    do_reset(0);
    set_idle(); ex_mem_read = 1; ex_rt = 2; id_rs = 2;
    #1;
    check("lu_pc_en", pc_en, 0);
    check("lu_if_id_en", if_id_en, 0);
    check("lu_id_ex_flush", id_ex_flush, 1);
    step_cycle();
    check("lu_stall_cnt", stall_cnt, 1);
    set_idle(); ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    #1;
    check("lu_r0_pc_en", pc_en, 1);
    step_cycle();
    check("lu_r0_stall_cnt", stall_cnt, 1);

    // branch + stall + jump together: branch wins
    set_idle(); ex_mem_read = 1; ex_rt = 2; id_rs = 2;
    ex_branch_taken = 1; ex_branch_target = 32'h50; id_jump = 1; id_jump_target = 32'h30;
    #1;
    check("br_addr", redirect_addr, 32'h50);
    check("br_if_id_flush", if_id_flush, 1);
    check("br_id_ex_flush", id_ex_flush, 1);
    step_cycle();
    check("br_stall_cnt", stall_cnt, 1);
    check("br_flush_cnt", flush_cnt, 1);

    // plain jump
    set_idle(); id_jump = 1; id_jump_target = 32'h30;
    #1;
    check("jmp_redirect", redirect, 1);
    check("jmp_addr", redirect_addr, 32'h30);
    check("jmp_if_id_flush", if_id_flush, 1);
    check("jmp_id_ex_flush", id_ex_flush, 0);
    step_cycle();
    check("jmp_flush_cnt", flush_cnt, 2);

    // last IMEM word triggers drain and halt
    set_idle(); pc = 32'h1FC;
    #1;
    step_cycle();
    set_idle();
    bubbles = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (halted) break;
      if (pipe_en && if_id_flush && !pc_en) bubbles++;
      step_cycle();
    end
    check("drain_bubbles", bubbles, DRAIN);
    check("halt_halted", halted, 1);
    check("halt_pipe_en", pipe_en, 0);
    for (int i = 0; i < 3; i++) begin
      step = 1; pc = 32'h10;
      step_cycle();
      #1;
    end

    // single-step: three pulses, three advance cycles
    @(negedge clk);
    do_reset(1);
    pe_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      set_idle(); pc = 32'(i) << 2; step = (i == 1 || i == 4 || i == 7);
      #1;
      if (pipe_en) pe_cycles++;
      step_cycle();
    end
    check("step_pipe_en_cycles", pe_cycles, 3);

    // reset in the middle of a drain
    do_reset(0);
    set_idle(); pc = 32'h1FC;
    #1;
    step_cycle();
    set_idle();
    #1;
    step_cycle();
    do_reset(0);
    set_idle();
    #1;
    check("postrst_pipe_en", pipe_en, 1);
    check("postrst_pc_en", pc_en, 1);
    step_cycle();

    // randomized episodes
    for (int ep = 0; ep < 14; ep++) begin
      do_reset(1'($urandom_range(0, 1)));
      for (int c = 0; c < 150; c++) begin
        rand_inputs(c != 0);
        #1;
        step_cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central control block for the 5-stage MIPS pipeline on the Nexys4 build. It sits beside the instruction-fetch stage and owns every stage-enable and flush strobe: load-use stalls, branch/jump redirect priority, the end-of-program drain and halt, and a board-button single-step mode. Fetch, IF/ID and ID/EX registers consume its strobes directly; it holds no datapath state beyond two event counters.

## Interface
- `IMEM_DEPTH`, 128: instruction-memory words; last legal word index is IMEM_DEPTH-1.
- `DRAIN_CYCLES`, 4: bubble cycles between halt decision and `halted`.
- `CNT_W`, 16: width of the stall/flush counters.

- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset asserted).
- `run_mode` in 1: 0 free-run, 1 single-step; level, pre-synchronized.
- `step` in 1: one-cycle pulse, debounced and synchronized upstream.
- `halt_req` in 1: external halt request, level.
- `pc` in 32: current fetch PC.
- `id_rs`, `id_rt` in 5 each: decode-stage source registers; `id_uses_rt` in 1.
- `ex_mem_read` in 1, `ex_rt` in 5: instruction in EX is a load, and its destination.
- `ex_branch_taken` in 1, `ex_branch_target` in 32: resolved branch from EX.
- `id_jump` in 1, `id_jump_target` in 32: jump decoded in ID.
- `pipe_en` out 1: global advance enable for all pipeline registers.
- `pc_en`, `if_id_en` out 1 each: PC and IF/ID write enables.
- `if_id_flush`, `id_ex_flush` out 1 each: load NOP into that register.
- `redirect` out 1, `redirect_addr` out 32: fetch takes `redirect_addr` instead of PC+4.
- `halted` out 1; `stall_cnt`, `flush_cnt` out CNT_W.

## Operation
- States: RUN, STEP_WAIT, DRAIN, HALT. Reset state RUN if `run_mode`=0, STEP_WAIT if 1 (sampled at reset release).
- `pipe_en`: 1 in RUN and DRAIN; in STEP_WAIT equals `step`; 0 in HALT. All other strobes are gated by `pipe_en` (forced 0 when `pipe_en`=0).
- Load-use hazard: `ex_mem_read` & `ex_rt`≠0 & (`ex_rt`==`id_rs` | (`id_uses_rt` & `ex_rt`==`id_rt`)). Response: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, one cycle; stall_cnt+1.
- Priority, highest first: (1) `ex_branch_taken`: redirect=1, addr=`ex_branch_target`, `if_id_flush`=1, `id_ex_flush`=1, pc_en=1; overrides hazard and jump; flush_cnt+1. (2) load-use stall; any concurrent `id_jump` is ignored this cycle and re-presented next cycle. (3) `id_jump`: redirect=1, addr=`id_jump_target`, `if_id_flush`=1; flush_cnt+1. (4) default: pc_en=if_id_en=1, no flush.
- Halt decision (RUN or STEP_WAIT, `pipe_en`=1): `halt_req`=1, or `pc[10:2]` ≥ IMEM_DEPTH-1, or `pc[31:11]`≠0 -> DRAIN. Taken branch in the same cycle still redirects; DRAIN is entered anyway.
- DRAIN: pc_en=0, if_id_en=1, `if_id_flush`=1 every cycle (bubbles), id_ex logic normal; after DRAIN_CYCLES cycles -> HALT.
- HALT: all strobes 0, `halted`=1. Exit only via reset.
- `run_mode` changes take effect next cycle between RUN and STEP_WAIT only; ignored in DRAIN/HALT.
- Counters saturate at all-ones; count only when `pipe_en`=1.

## Timing
- Strobes are combinational from registered state plus current inputs: zero-cycle latency, valid before the same rising edge.
- State, drain counter, event counters update on rising `clk`.
- Reset (any time, incl. mid-DRAIN): state per above, counters 0, `halted`=0, drain counter 0; outputs immediately reflect the reset state.
- Step pulse longer than one cycle advances one instruction per high cycle.

## Structure
- Shared package: state encoding (2-bit), NOP word 32'h0000_0020, redirect-priority constants.
- One sub-module: `hazard_detect` (combinational load-use compare); the rest lives in `pipeline_sequencer`.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=2, id_rs=2 -> one cycle pc_en=0, id_ex_flush=1; stall_cnt 0->1; ex_rt=0 -> no stall.
- Branch+stall+jump same cycle, target 0x50 -> redirect_addr=0x50, both flushes 1, stall_cnt unchanged, flush_cnt+1.
- Jump in ID to 0x30 -> redirect=1, if_id_flush=1, id_ex_flush=0.
- pc=0x1FC (index 127) -> 4 bubble cycles, then halted=1, pipe_en=0 thereafter.
- run_mode=1, three step pulses -> pipe_en high exactly 3 cycles; no PC advance without step.
- rst low mid-DRAIN -> halted=0, counters 0, state RUN on release.
